cpu_sequencer: RTL
==================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port run, input, 1 bit: fetch enable; when 0, no new fetch is issued.
REQ-005 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-007 SHALL have port imem_addr, output, 32 bits: fetch address.
REQ-008 SHALL have port imem_rsp_valid, input, 1 bit: fetch data valid.
REQ-009 SHALL have port imem_rsp_data, input, 32 bits: fetched instruction word.
REQ-010 SHALL have port instr, output, 32 bits: instruction register, driven to the decoder.
REQ-011 SHALL have port decode_ce, output, 1 bit: decoder clock-enable strobe.
REQ-012 SHALL have port dec_regfile_we, input, 1 bit: write request from the decoder.
REQ-013 SHALL have port dec_illegal, input, 1 bit: decoder flags an unsupported opcode.
REQ-014 SHALL have port regfile_we, output, 1 bit: gated register-file write enable.
REQ-015 SHALL have port pc, output, 32 bits: current program counter.
REQ-016 SHALL have port instret, output, 32 bits: retired-instruction counter.
REQ-017 SHALL have port halted, output, 1 bit: the core is in HALT.

Function
REQ-018 SHALL implement the states FETCH, WAIT, DECODE, WRITEBACK and HALT.
REQ-019 FETCH: SHALL drive imem_req_valid=run and imem_addr=pc; on imem_req_valid & imem_req_ready, SHALL go to WAIT; otherwise SHALL stay in FETCH.
REQ-020 Once asserted, imem_req_valid and imem_addr SHALL hold stable until accepted; run falling while a request is pending SHALL NOT withdraw it.
REQ-021 WAIT: on imem_rsp_valid, SHALL set instr <= imem_rsp_data and go to DECODE; otherwise SHALL stay in WAIT.
REQ-022 imem_rsp_valid outside WAIT SHALL be ignored, and instr SHALL be unchanged.
REQ-023 DECODE: SHALL assert decode_ce for exactly one cycle, then go to WRITEBACK.
REQ-024 WRITEBACK without dec_illegal: regfile_we = dec_regfile_we for one cycle; pc <= pc+4 modulo 2^32; instret <= instret+1 modulo 2^32; next state FETCH.
REQ-025 WRITEBACK with dec_illegal: regfile_we=0, pc and instret unchanged, next state HALT.
REQ-026 HALT: SHALL be left only by reset; halted=1 and all strobes 0.
REQ-027 regfile_we and decode_ce SHALL be 0 in every state other than those given above.
REQ-028 Minimum latency SHALL be 4 cycles per instruction (ready in FETCH, response on the next cycle).
REQ-029 The block SHALL NOT have any outstanding-fetch limit other than one request in flight.

Reset
REQ-030 On rst=1: state=FETCH, pc=RESET_PC, instr=0, instret=0; imem_req_valid, decode_ce, regfile_we and halted = 0; all take effect immediately and asynchronously.
REQ-031 Reset mid-transaction SHALL abandon the fetch; a late imem_rsp_valid after reset (state FETCH) SHALL be ignored.
REQ-032 After rst deasserts, the first request SHALL be at RESET_PC in the first cycle with run=1.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Reset, run=1, ready=1, response 1 cycle later with 0x123450B7 (LUI), dec_regfile_we=1 -> imem_addr=0, decode_ce pulse in cycle 3, regfile_we pulse in cycle 4, pc=4, instret=1.
- ready held 0 for 5 cycles with run toggled -> imem_req_valid and addr stay stable; single transfer; no duplicate fetch.
- dec_illegal=1 in WRITEBACK -> regfile_we=0, halted=1, pc and instret frozen; further responses ignored.
- RESET_PC=32'hFFFF_FFFC -> after one retire, pc=0 (wrap).
- rst asserted in WAIT, then a stray rsp_valid -> instr=0, state FETCH, addr=RESET_PC.
- run=0 in FETCH -> no request; run=1 -> request within 1 cycle.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/writeback sequencer for a simple in-order core.
// One instruction memory request in flight at a time; each instruction walks
// FETCH -> WAIT -> DECODE -> WRITEBACK and an illegal opcode parks the core
// in HALT until reset.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic        decode_ce,
  input  logic        dec_regfile_we,
  input  logic        dec_illegal,
  output logic        regfile_we,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_WAIT      = 3'd1,
    ST_DECODE    = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] instret_r, instret_s;
  // Set once a request has been presented but not yet accepted, so that a
  // falling run cannot withdraw it.
  logic        pending_r, pending_s;
  logic        req_valid_s;
  logic        decode_ce_s;
  logic        regfile_we_s;

  // State and architectural registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      pc_r      <= RESET_PC;
      instr_r   <= 32'h0000_0000;
      instret_r <= 32'h0000_0000;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      instr_r   <= instr_s;
      instret_r <= instret_s;
      pending_r <= pending_s;
    end
  end

  // Next-state, register updates and strobes for the sequencer FSM.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    instr_s      = instr_r;
    instret_s    = instret_r;
    pending_s    = pending_r;
    req_valid_s  = 1'b0;
    decode_ce_s  = 1'b0;
    regfile_we_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        req_valid_s = run | pending_r;
        if (req_valid_s && imem_req_ready) begin
          pending_s = 1'b0;
          state_s   = ST_WAIT;
        end else if (req_valid_s) begin
          pending_s = 1'b1;
        end else begin
          pending_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          instr_s = imem_rsp_data;
          state_s = ST_DECODE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DECODE: begin
        decode_ce_s = 1'b1;
        state_s     = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        if (dec_illegal) begin
          state_s = ST_HALT;
        end else begin
          regfile_we_s = dec_regfile_we;
          pc_s         = pc_r + 32'd4;
          instret_s    = instret_r + 32'd1;
          state_s      = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_s = ST_HALT;
      end
      default: begin
        // Unreachable encodings park the core safely.
        state_s   = ST_HALT;
        pending_s = 1'b0;
      end
    endcase
  end

  // Request valid is also masked by rst so it drops the instant reset rises.
  assign imem_req_valid = req_valid_s & ~rst;
  assign imem_addr      = pc_r;
  assign instr          = instr_r;
  assign decode_ce      = decode_ce_s;
  assign regfile_we     = regfile_we_s;
  assign pc             = pc_r;
  assign instret        = instret_r;
  assign halted         = (state_r == ST_HALT);

endmodule
